// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - byte-addressable MEM-stage data memory with power-up clear sweep
// Optional feature macro: PARITY_EN (per-byte even parity storage and load-time check)
module data_memory_ctrl #(
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 32,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              misalign,
  output logic              parity_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] clr_idx;
  logic          clr_we;
  logic          idle_c;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          legal;
  logic          accept;
  logic          do_store;
  logic [3:0]    be;
  logic [31:0]   wd;

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  logic          s1_load, s1_bad, s1_uns;
  logic [1:0]    s1_size, s1_off;
  logic [31:0]   s1_word;
  logic [31:0]   ext;

  // Address bits above the word index are deliberately ignored (wrap-around).
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[ADDR_W-1:AW+2];

  // State register; reset restarts the clear sweep (or goes straight to IDLE when clearing is disabled)
  always_ff @(posedge clk) begin
    if (rst) begin
      if (INIT_CLEAR) state <= CLEAR;
      else            state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: sweep one word per cycle, leave CLEAR after the last index
  always_comb begin
    state_nx = state;
    clr_we   = 1'b0;
    idle_c   = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_idx == AW'(DEPTH - 1)) state_nx = IDLE;
      end
      IDLE: idle_c = 1'b1;
      default: state_nx = IDLE;
    endcase
  end

  assign ready = idle_c & ~rst;

  // Sweep index counter
  always_ff @(posedge clk) begin
    if (rst)         clr_idx <= '0;
    else if (clr_we) clr_idx <= clr_idx + AW'(1);
  end

  // Request decode: word index, alignment legality, lane enables and replicated store data
  always_comb begin
    idx    = addr[AW+1:2];
    off    = addr[1:0];
    accept = req_valid & ready;
    be     = 4'b1111;
    wd     = wdata;
    legal  = 1'b0;
    case (req_size)
      2'b00: begin
        legal = 1'b1;
        be    = 4'b0001 << off;
        wd    = {4{wdata[7:0]}};
      end
      2'b01: begin
        legal = ~off[0];
        be    = off[1] ? 4'b1100 : 4'b0011;
        wd    = {2{wdata[15:0]}};
      end
      2'b10: legal = (off == 2'b00);
      default: legal = 1'b0;
    endcase
    do_store = accept & req_write & legal;
  end

  // Single write port shared by the clear sweep and stores (the two never overlap)
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_be   = be;
    wr_data = wd;
    if (clr_we && !rst) begin
      wr_en   = 1'b1;
      wr_idx  = clr_idx;
      wr_be   = 4'b1111;
      wr_data = '0;
    end else if (do_store) begin
      wr_en = 1'b1;
    end
  end

  // Data array write with byte-lane enables
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read stage: capture the addressed word and access attributes on the accepting edge
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_load <= 1'b0;
      s1_bad  <= 1'b0;
    end else begin
      s1_load <= accept & ~req_write;
      s1_bad  <= accept & ~legal;
    end
    s1_word <= mem[idx];
    s1_off  <= off;
    s1_size <= req_size;
    s1_uns  <= req_unsigned;
  end

  // Lane selection and sign/zero extension of the captured word
  always_comb begin
    ext = s1_word;
    case (s1_size)
      2'b00: begin
        ext[7:0]  = s1_word[{s1_off, 3'b000} +: 8];
        ext[31:8] = (s1_uns ? 24'h0 : {24{ext[7]}});
      end
      2'b01: begin
        ext[15:0]  = s1_off[1] ? s1_word[31:16] : s1_word[15:0];
        ext[31:16] = (s1_uns ? 16'h0 : {16{ext[15]}});
      end
      default: ext = s1_word;
    endcase
  end

  // Response stage: rdata holds until the next completing load; pulses last one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      rdata_valid <= s1_load;
      misalign    <= s1_bad;
      if (s1_load) rdata <= s1_bad ? 32'h0 : ext;
    end
  end

`ifdef PARITY_EN
  logic [3:0] par_mem [DEPTH];
  logic [3:0] s1_par;
  logic [3:0] s1_mask;
  logic [3:0] lane_par;

  // Parity array write: one even-parity bit per lane, zero data gives zero parity on clear
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) par_mem[wr_idx][i] <= ^wr_data[8*i +: 8];
      end
    end
  end

  // Capture stored parity and the lanes this load reads
  always_ff @(posedge clk) begin
    s1_par  <= par_mem[idx];
    s1_mask <= be;
  end

  // Recompute parity of the captured lanes
  always_comb begin
    lane_par = '0;
    for (int i = 0; i < 4; i++) lane_par[i] = ^s1_word[8*i +: 8];
  end

  // Flag a mismatch on any checked lane alongside rdata_valid
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= s1_load & ~s1_bad & (|(s1_mask & (s1_par ^ lane_par)));
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - directed self-checking bench for data_memory_ctrl
module tb_data_memory_ctrl;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misalign;
  logic        parity_err;

  int total = 0;
  int bad   = 0;

  data_memory_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .rdata_valid(rdata_valid), .misalign(misalign),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // Issue one request at a negedge; returns at the negedge after the accepting edge
  task automatic req(input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Count cycles with ready low after rst drops
  task automatic wait_sweep(output int cnt);
    cnt = 0;
    while (!ready && cnt <= DEPTH + 8) begin
      step();
      cnt++;
    end
  endtask

  task automatic test_reset();
    int cnt;
    logic [31:0] a_t [3];
    a_t = '{32'h0, 32'h4, 32'((DEPTH - 1) * 4)};
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({ready, rdata_valid, misalign, parity_err} !== 4'b0000 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%b rdata=%h exp=0000 rdata=0",
               {ready, rdata_valid, misalign, parity_err}, rdata);
    end
    rst = 1'b0;
    wait_sweep(cnt);
    total++;
    if (cnt !== DEPTH) begin
      bad++;
      $display("FAIL sweep_len got=%0d exp=%0d", cnt, DEPTH);
    end
    for (int i = 0; i < 3; i++) begin
      req(1'b0, 2'b10, 1'b0, a_t[i], 32'h0);
      step();
      total++;
      if (rdata_valid !== 1'b1 || rdata !== 32'h0) begin
        bad++;
        $display("FAIL cleared_word[%h] got=%h v=%b exp=00000000 v=1", a_t[i], rdata, rdata_valid);
      end
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] a_t [5];
    logic        u_t [5];
    logic [31:0] e_t [5];
    a_t = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h13};
    u_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    e_t = '{32'hFFFFFFEF, 32'hFFFFFFBE, 32'hFFFFFFAD, 32'hFFFFFFDE, 32'h000000DE};
    req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    step();
    total++;
    if (rdata_valid !== 1'b0 || misalign !== 1'b0) begin
      bad++;
      $display("FAIL store_no_resp got v=%b m=%b exp v=0 m=0", rdata_valid, misalign);
    end
    for (int i = 0; i < 5; i++) begin
      req(1'b0, 2'b00, u_t[i], a_t[i], 32'h0);
      step();
      total++;
      if (rdata_valid !== 1'b1 || rdata !== e_t[i]) begin
        bad++;
        $display("FAIL byte_load[%h u=%b] got=%h v=%b exp=%h", a_t[i], u_t[i], rdata, rdata_valid, e_t[i]);
      end
    end
  endtask

  task automatic test_sub_word();
    req(1'b1, 2'b00, 1'b0, 32'h21, 32'hAAAAAA55);
    req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    step();
    total++;
    if (rdata !== 32'h00005500) begin
      bad++;
      $display("FAIL byte_store_word got=%h exp=00005500", rdata);
    end
    req(1'b1, 2'b01, 1'b0, 32'h22, 32'h77778001);
    req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    step();
    total++;
    if (rdata !== 32'hFFFF8001) begin
      bad++;
      $display("FAIL half_signed got=%h exp=FFFF8001", rdata);
    end
    req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    step();
    total++;
    if (rdata !== 32'h00008001) begin
      bad++;
      $display("FAIL half_unsigned got=%h exp=00008001", rdata);
    end
    req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    step();
    total++;
    if (rdata !== 32'h80015500) begin
      bad++;
      $display("FAIL half_store_word got=%h exp=80015500", rdata);
    end
  endtask

  task automatic test_misalign();
    req(1'b1, 2'b10, 1'b0, 32'h04, 32'hA5A5A5A5);
    req(1'b1, 2'b10, 1'b0, 32'h06, 32'h11111111);
    step();
    total++;
    if (misalign !== 1'b1 || rdata_valid !== 1'b0) begin
      bad++;
      $display("FAIL mis_store got m=%b v=%b exp m=1 v=0", misalign, rdata_valid);
    end
    step();
    total++;
    if (misalign !== 1'b0) begin
      bad++;
      $display("FAIL mis_pulse_len got=%b exp=0", misalign);
    end
    req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    step();
    total++;
    if (rdata !== 32'hA5A5A5A5 || misalign !== 1'b0) begin
      bad++;
      $display("FAIL mis_store_unchanged got=%h m=%b exp=A5A5A5A5 m=0", rdata, misalign);
    end
    req(1'b0, 2'b01, 1'b0, 32'h03, 32'h0);
    step();
    total++;
    if (misalign !== 1'b1 || rdata_valid !== 1'b1 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL mis_half_load got m=%b v=%b d=%h exp m=1 v=1 d=0", misalign, rdata_valid, rdata);
    end
    req(1'b0, 2'b11, 1'b0, 32'h04, 32'h0);
    step();
    total++;
    if (misalign !== 1'b1 || rdata_valid !== 1'b1) begin
      bad++;
      $display("FAIL reserved_size got m=%b v=%b exp m=1 v=1", misalign, rdata_valid);
    end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    addr = 32'h40; wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b0; wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (rdata_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_early got v=%b exp=0", rdata_valid);
    end
    step();
    total++;
    if (rdata_valid !== 1'b1 || rdata !== 32'h12345678) begin
      bad++;
      $display("FAIL b2b_load got=%h v=%b exp=12345678 v=1", rdata, rdata_valid);
    end
    step();
    total++;
    if (rdata_valid !== 1'b0 || rdata !== 32'h12345678) begin
      bad++;
      $display("FAIL rdata_hold got=%h v=%b exp=12345678 v=0", rdata, rdata_valid);
    end
    req(1'b0, 2'b10, 1'b0, 32'(32'h40 + DEPTH * 4), 32'h0);
    step();
    total++;
    if (rdata_valid !== 1'b1 || rdata !== 32'h12345678) begin
      bad++;
      $display("FAIL alias_load got=%h v=%b exp=12345678 v=1", rdata, rdata_valid);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; addr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    total++;
    if (rdata_valid !== 1'b0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL drop_inflight got=%h v=%b exp=0 v=0", rdata, rdata_valid);
    end
    rst = 1'b0;
    repeat (300) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_sweep(cnt);
    total++;
    if (cnt !== DEPTH) begin
      bad++;
      $display("FAIL resweep_len got=%0d exp=%0d", cnt, DEPTH);
    end
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    step();
    total++;
    if (rdata_valid !== 1'b1 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL resweep_low_word got=%h exp=00000000", rdata);
    end
  endtask

  task automatic test_parity();
    req(1'b1, 2'b10, 1'b0, 32'h80, 32'h0F0F0F0F);
    req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    step();
    total++;
    if (parity_err !== 1'b0 || rdata !== 32'h0F0F0F0F) begin
      bad++;
      $display("FAIL parity_clean got pe=%b d=%h exp pe=0 d=0F0F0F0F", parity_err, rdata);
    end
`ifdef PARITY_EN
    dut.par_mem[32][2] = ~dut.par_mem[32][2];
    req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    step();
    total++;
    if (parity_err !== 1'b1 || rdata_valid !== 1'b1 || rdata !== 32'h0F0F0F0F) begin
      bad++;
      $display("FAIL parity_flip got pe=%b v=%b d=%h exp pe=1 v=1 d=0F0F0F0F", parity_err, rdata_valid, rdata);
    end
    req(1'b0, 2'b00, 1'b0, 32'h80, 32'h0);
    step();
    total++;
    if (parity_err !== 1'b0 || rdata !== 32'h0000000F) begin
      bad++;
      $display("FAIL parity_other_lane got pe=%b d=%h exp pe=0 d=0000000F", parity_err, rdata);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_sub_word();
    test_misalign();
    test_back_to_back();
    test_reset_mid_sweep();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised byte-addressable data memory for the 32-bit pipeline MEM stage. It replaces the fixed 1024-word, word-only data memory. It adds byte, halfword and word accesses, sign/zero-extended loads, a registered 1-cycle read, and misalignment reporting. After reset, an FSM sweeps the array to zero, and requests are back-pressured until the sweep is done.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, >= 4
ADDR_W, 32, byte-address width from the ALU
INIT_CLEAR, 1, 1 = zero the array after reset; 0 = skip the sweep (contents undefined)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset
req_valid  in  1  access request this cycle
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
addr  in  ADDR_W  byte address
wdata  in  32  store data, right-aligned
ready  out  1  request accepted when req_valid & ready
rdata  out  32  extended load result
rdata_valid  out  1  one-cycle pulse, rdata valid
misalign  out  1  one-cycle pulse, illegal/misaligned access
parity_err  out  1  one-cycle pulse on parity mismatch (PARITY_EN only; else constant 0)

Behaviour:
- Reset: rst is synchronous, active-high.
  - Reset values: state=CLEAR (IDLE if INIT_CLEAR=0), clr_idx=0, ready=0, rdata=0, rdata_valid=0, misalign=0, parity_err=0.
  - Asserting rst mid-sweep or mid-access restarts the sweep at index 0. Any in-flight read result is dropped.
- FSM states: CLEAR, IDLE.
  - CLEAR: write 0 to mem[clr_idx], then clr_idx++. ready=0 throughout. After writing index DEPTH-1, go to IDLE.
  - The sweep takes exactly DEPTH cycles after rst deasserts.
  - IDLE: ready=1. One request is accepted per cycle, back-to-back, with no bubbles.
- Word index = addr[$clog2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4 bytes.
- Alignment:
  - Byte: always legal.
  - Half: legal only if addr[0]=0.
  - Word: legal only if addr[1:0]=0.
  - size 11: always illegal.
- Illegal accepted request:
  - Memory is unchanged.
  - Next cycle: misalign=1.
  - If it was a load, also rdata=0 and rdata_valid=1.
- Store: updates memory at the accepting edge, using byte-lane write enables.
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
  - Word: all 4 lanes.
  - Stores never produce rdata_valid.
- Load: 1-cycle latency.
  - Accepted at edge N; at edge N+1, rdata holds the selected lane(s), sign- or zero-extended to 32 bits, and rdata_valid=1.
  - rdata holds its value until the next load completes. rdata_valid=0 in every cycle without a completing load.
- Store at edge N followed by a load of the same word at edge N+1: the load returns the newly stored data.
- Requests presented while ready=0 are ignored. They are not queued.

Optional Feature:
PARITY_EN:
- Defined:
  - Each byte lane stores one extra even-parity bit, computed on write; the clear sweep writes parity 0.
  - On load completion, the lanes that were read are checked. parity_err=1 in the same cycle as rdata_valid if any checked lane mismatches.
  - rdata is still delivered.
- Undefined:
  - No parity storage; parity_err is constant 0.

Test Plan:
1. Reset sweep: rst high 2 cycles, then low. ready=0 for exactly DEPTH cycles, then 1. A word load from 0x0, 0x4 and (DEPTH-1)*4 each returns 0x00000000.
2. Store 0xDEADBEEF at 0x10, then byte loads at 0x10..0x13:
   - signed: 0xFFFFFFEF, 0xFFFFFFBE, 0xFFFFFFAD, 0xFFFFFFDE
   - unsigned at 0x13: 0x000000DE
3. Store byte 0x55 at 0x21, after word 0x21 was 0x00000000. Word load 0x20 returns 0x00005500. Half signed load 0x22 after a half store of 0x8001 returns 0xFFFF8001.
4. Misalignment:
   - word store to 0x06: misalign pulses 1 cycle, memory unchanged (word load 0x04 returns its old value)
   - half load at 0x03: misalign=1, rdata_valid=1, rdata=0
5. Back-to-back: store 0x12345678 to 0x40 at edge N, load 0x40 at N+1. rdata=0x12345678 with rdata_valid at N+2. Address 0x40+DEPTH*4 aliases to the same word.
6. Reset during the sweep at clr_idx=300: the sweep restarts at 0, and ready rises DEPTH cycles after the second rst deasserts. With PARITY_EN, force-flip a stored parity bit; a load of that word gives parity_err=1 alongside rdata_valid.
